// File: rtl/bus_master_unit.sv
`timescale 1ns/1ps
// ============================================================================
// bus_master_unit
// ----------------------------------------------------------------------------
// Single-port bus master that sits between the CPU control unit and the
// memory/peripheral bus. It accepts one read or write request at a time,
// runs a req/ack handshake with wait states and a timeout, and reports the
// result back to the control unit as a one-cycle pulse.
//
// Parameters
//   TIMEOUT                cycles mem_req is held without mem_ack before the
//                          transaction is aborted (legal range 2..255)
//
// Ports
//   clk                    system clock, rising edge
//   rst                    synchronous, active-high reset
//   BUS_start_transaction  one-cycle request pulse from the control unit
//   BUS_mode               0 = read, 1 = write (sampled with the start pulse)
//   BUS_addr[31:0]         byte address (sampled with the start pulse)
//   BUS_wdata[31:0]        store data (sampled with the start pulse)
//   BUS_rdata[31:0]        last successfully read word
//   BUS_rdata_valid        pulse: read completed, BUS_rdata valid
//   BUS_write_done         pulse: write accepted by the bus
//   BUS_busy               transaction in flight (through completion/error)
//   BUS_error              pulse: misaligned address or timeout
//   mem_req                bus request, held until ack or timeout
//   mem_we                 write enable, qualified by mem_req
//   mem_addr[31:0]         word-aligned bus address
//   mem_wdata[31:0]        bus write data
//   mem_ack                slave acknowledge (read data valid same cycle)
//   mem_rdata[31:0]        slave read data
//
// Every output comes straight from a flop, so there is no combinational
// path from mem_ack (or any other input) to an output.
// ============================================================================
module bus_master_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        BUS_start_transaction,
    input  logic        BUS_mode,
    input  logic [31:0] BUS_addr,
    input  logic [31:0] BUS_wdata,
    output logic [31:0] BUS_rdata,
    output logic        BUS_rdata_valid,
    output logic        BUS_write_done,
    output logic        BUS_busy,
    output logic        BUS_error,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR
    } state_e;

    // Counter value seen in the last REQ cycle before the abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;

    // Holding registers for the accepted request.
    logic        mode_q,  mode_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q,   cnt_d;

    // Registered outputs.
    logic        req_q,   req_d;
    logic        we_q,    we_d;
    logic        valid_q, valid_d;
    logic        done_q,  done_d;
    logic        busy_q,  busy_d;
    logic        error_q, error_d;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // mem_ack is deliberately not looked at here: a stray ack
                // while idle must not disturb anything.
                if (BUS_start_transaction) begin
                    if (BUS_addr[1:0] == 2'b00) begin
                        mode_d  = BUS_mode;
                        addr_d  = BUS_addr;
                        wdata_d = BUS_wdata;
                        cnt_d   = 8'd0;
                        state_d = ST_REQ;
                    end else begin
                        // Misaligned: report the error without touching
                        // the bus or the holding registers.
                        state_d = ST_ERR;
                    end
                end
            end

            ST_REQ: begin
                // Ack is checked before the timeout so an ack in the last
                // allowed cycle still completes the transaction.
                if (mem_ack) begin
                    if (!mode_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            // Completion and error states last exactly one cycle; any start
            // pulse seen here is dropped rather than queued.
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the state being entered, so once
        // registered they line up with the state they describe.
        req_d   = (state_d == ST_REQ);
        we_d    = (state_d == ST_REQ) && mode_d;
        valid_d = (state_d == ST_DONE) && !mode_d;
        done_d  = (state_d == ST_DONE) &&  mode_d;
        error_d = (state_d == ST_ERR);
        busy_d  = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the holding registers are reset as well, because they
            // drive mem_addr/mem_wdata/BUS_rdata directly and those outputs
            // have defined reset values.
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output ports
    // ------------------------------------------------------------------------
    // addr_q only ever holds an aligned address, so it is already the
    // word-aligned bus address.
    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign BUS_rdata       = rdata_q;
    assign BUS_rdata_valid = valid_q;
    assign BUS_write_done  = done_q;
    assign BUS_busy        = busy_q;
    assign BUS_error       = error_q;

endmodule

// File: tb/tb_bus_master_unit.sv
`timescale 1ns/1ps
// ============================================================================
// tb_bus_master_unit
// ----------------------------------------------------------------------------
// Self-checking bench for bus_master_unit. Each transaction's expected
// behaviour is computed from the handshake rules: how many cycles mem_req
// stays up given when the slave acks, which pulse follows, and what
// BUS_rdata must hold afterwards.
// ============================================================================
module tb_bus_master_unit;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        BUS_start_transaction;
    logic        BUS_mode;
    logic [31:0] BUS_addr;
    logic [31:0] BUS_wdata;
    logic [31:0] BUS_rdata;
    logic        BUS_rdata_valid;
    logic        BUS_write_done;
    logic        BUS_busy;
    logic        BUS_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    bus_master_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .BUS_start_transaction (BUS_start_transaction),
        .BUS_mode              (BUS_mode),
        .BUS_addr              (BUS_addr),
        .BUS_wdata             (BUS_wdata),
        .BUS_rdata             (BUS_rdata),
        .BUS_rdata_valid       (BUS_rdata_valid),
        .BUS_write_done        (BUS_write_done),
        .BUS_busy              (BUS_busy),
        .BUS_error             (BUS_error),
        .mem_req               (mem_req),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_ack               (mem_ack),
        .mem_rdata             (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'h0;   // last word a successful read returned

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req"},   32'(mem_req),         32'd0);
        check({tag, ".we"},    32'(mem_we),          32'd0);
        check({tag, ".valid"}, 32'(BUS_rdata_valid), 32'd0);
        check({tag, ".done"},  32'(BUS_write_done),  32'd0);
        check({tag, ".error"}, 32'(BUS_error),       32'd0);
        check({tag, ".busy"},  32'(BUS_busy),        32'd0);
        check({tag, ".rdata"}, BUS_rdata,            exp_rdata);
    endtask

    task automatic check_reset_vals(input string tag);
        exp_rdata = 32'h0;
        check_idle(tag);
        check({tag, ".addr"},  mem_addr,  32'h0);
        check({tag, ".wdata"}, mem_wdata, 32'h0);
    endtask

    // One transaction. ack_at is the REQ cycle (0-based) in which the slave
    // acks, or -1 for never. extra bit0 pulses a competing start in the
    // first REQ cycle, bit1 in the completion/error cycle; both must be
    // dropped. Called and returns at +1 after an edge with the DUT idle.
    task automatic txn(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_at, input logic [31:0] rd, input logic [1:0] extra,
                       input string tag);
        bit acked;
        int n_req;
        BUS_start_transaction = 1'b1;
        BUS_mode  = mode;
        BUS_addr  = addr;
        BUS_wdata = wdata;
        tick();
        BUS_start_transaction = 1'b0;

        if (addr[1:0] != 2'b00) begin
            check({tag, ".mis_error"}, 32'(BUS_error),       32'd1);
            check({tag, ".mis_req"},   32'(mem_req),         32'd0);
            check({tag, ".mis_valid"}, 32'(BUS_rdata_valid), 32'd0);
            check({tag, ".mis_done"},  32'(BUS_write_done),  32'd0);
            check({tag, ".mis_rdata"}, BUS_rdata,            exp_rdata);
        end else begin
            acked = (ack_at >= 0) && (ack_at < TIMEOUT);
            n_req = acked ? ack_at + 1 : TIMEOUT;
            for (int c = 0; c < n_req; c++) begin
                check({tag, ".req"},   32'(mem_req),         32'd1);
                check({tag, ".we"},    32'(mem_we),          32'(mode));
                check({tag, ".addr"},  mem_addr,             addr);
                if (mode) check({tag, ".wdata"}, mem_wdata, wdata);
                check({tag, ".busy"},  32'(BUS_busy),        32'd1);
                check({tag, ".pulse"}, 32'({BUS_rdata_valid, BUS_write_done, BUS_error}), 32'd0);
                mem_ack   = (c == ack_at);
                mem_rdata = mem_ack ? rd : $urandom();
                if (c == 0 && extra[0]) begin
                    BUS_start_transaction = 1'b1;
                    BUS_mode  = ~mode;
                    BUS_addr  = $urandom();
                    BUS_wdata = $urandom();
                end
                tick();
                mem_ack = 1'b0;
                BUS_start_transaction = 1'b0;
            end
            if (acked && !mode) exp_rdata = rd;
            check({tag, ".end_req"},   32'(mem_req),         32'd0);
            check({tag, ".end_busy"},  32'(BUS_busy),        32'd1);
            check({tag, ".end_valid"}, 32'(BUS_rdata_valid), 32'(acked && !mode));
            check({tag, ".end_done"},  32'(BUS_write_done),  32'(acked && mode));
            check({tag, ".end_error"}, 32'(BUS_error),       32'(!acked));
            check({tag, ".end_rdata"}, BUS_rdata,            exp_rdata);
        end

        if (extra[1]) begin
            BUS_start_transaction = 1'b1;
            BUS_mode  = $urandom_range(0, 1) != 0;
            BUS_addr  = $urandom();
            BUS_wdata = $urandom();
        end
        tick();
        BUS_start_transaction = 1'b0;
        check_idle({tag, ".after"});
    endtask

    task automatic stray_ack(input string tag);
        mem_ack   = 1'b1;
        mem_rdata = $urandom();
        tick();
        mem_ack = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          ack_at;

        rst = 1'b1;
        BUS_start_transaction = 1'b0;
        BUS_mode  = 1'b0;
        BUS_addr  = 32'h0;
        BUS_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Directed cases from the handshake rules.
        txn(1'b0, 32'h100, 32'h0,        0,  32'hDEADBEEF, 2'b00, "read0");
        txn(1'b1, 32'h200, 32'h12345678, 3,  32'h0,        2'b00, "write3");
        txn(1'b0, 32'h400, 32'h0,        -1, 32'h55AA55AA, 2'b00, "timeout");
        txn(1'b0, 32'h102, 32'h0,        0,  32'h0,        2'b00, "misaligned");
        txn(1'b1, 32'h500, 32'hA5A5A5A5, 2,  32'h0,        2'b11, "ignored_start");
        txn(1'b0, 32'h600, 32'h0, TIMEOUT-1, 32'h13579BDF, 2'b00, "ack_last");
        stray_ack("stray_ack");

        // Reset in the middle of a read, with the ack arriving afterwards.
        BUS_start_transaction = 1'b1;
        BUS_mode = 1'b0;
        BUS_addr = 32'h300;
        tick();
        BUS_start_transaction = 1'b0;
        check("rst_mid.req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        check_reset_vals("rst_mid.1");
        tick();
        mem_ack = 1'b0;
        check_reset_vals("rst_mid.2");
        txn(1'b0, 32'h304, 32'h0, 1, 32'h0BADF00D, 2'b00, "fresh_read");

        // Randomized transactions with idle gaps and stray acks.
        for (int t = 0; t < 60; t++) begin
            a = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            if (r < 5)      ack_at = $urandom_range(0, 3);
            else if (r < 8) ack_at = $urandom_range(0, TIMEOUT + 1);
            else            ack_at = -1;
            txn($urandom_range(0, 1) != 0, a, $urandom(), ack_at, $urandom(),
                2'($urandom_range(0, 3)), "rand");
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                if ($urandom_range(0, 1) != 0) stray_ack("rand_stray");
                else begin
                    tick();
                    check_idle("rand_gap");
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
